// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data SRAM between the load/store path (port 0)
// and a second master (port 1), with bounded locked bursts and one-cycle read-return routing.
module dmem_arbiter #(
  parameter int unsigned AW        = 7,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_p0_req,
  input  logic          i_p0_we,
  input  logic          i_p0_lock,
  input  logic [AW-1:0] i_p0_addr,
  input  logic [DW-1:0] i_p0_wdata,
  input  logic          i_p1_req,
  input  logic          i_p1_we,
  input  logic          i_p1_lock,
  input  logic [AW-1:0] i_p1_addr,
  input  logic [DW-1:0] i_p1_wdata,
  output logic          o_p0_gnt,
  output logic          o_p1_gnt,
  output logic          o_p0_rvalid,
  output logic          o_p1_rvalid,
  output logic [DW-1:0] o_p0_rdata,
  output logic [DW-1:0] o_p1_rdata,
  output logic          o_mem_cen,
  output logic          o_mem_wen,
  output logic          o_mem_oen,
  output logic [AW-1:0] o_mem_a,
  output logic [DW-1:0] o_mem_d,
  input  logic [DW-1:0] i_mem_q
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e        r_state;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          r_pend;
  logic          r_owner;

  logic          w_keep0, w_keep1, w_keep;
  logic          w_g0, w_g1, w_any, w_sel;
  logic          w_we, w_lock;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  always_comb begin
    w_keep0 = (r_state == StLock0) && i_p0_req && i_p0_lock && (r_cnt < CW'(MAX_BURST));
    w_keep1 = (r_state == StLock1) && i_p1_req && i_p1_lock && (r_cnt < CW'(MAX_BURST));
    w_keep  = w_keep0 | w_keep1;
    w_g0    = 1'b0;
    w_g1    = 1'b0;
    if (!rst) begin
      w_g0 = 1'b0;
    end else if (w_keep0) begin
      w_g0 = 1'b1;
    end else if (w_keep1) begin
      w_g1 = 1'b1;
    end else if (i_p0_req && i_p1_req) begin
      // Tie goes to the port that was not granted last; in a lock state last is the lock owner.
      w_g0 = r_last;
      w_g1 = ~r_last;
    end else begin
      w_g0 = i_p0_req;
      w_g1 = i_p1_req;
    end
    w_any   = w_g0 | w_g1;
    w_sel   = w_g1;
    w_we    = w_sel ? i_p1_we    : i_p0_we;
    w_lock  = w_sel ? i_p1_lock  : i_p0_lock;
    w_addr  = w_sel ? i_p1_addr  : i_p0_addr;
    w_wdata = w_sel ? i_p1_wdata : i_p0_wdata;
  end

  assign o_p0_gnt  = w_g0;
  assign o_p1_gnt  = w_g1;
  assign o_mem_cen = ~w_any;
  assign o_mem_wen = w_any ? ~w_we : 1'b1;
  assign o_mem_oen = 1'b0;
  assign o_mem_a   = w_any ? w_addr  : '0;
  assign o_mem_d   = w_any ? w_wdata : '0;

  assign o_p0_rvalid = r_pend & ~r_owner;
  assign o_p1_rvalid = r_pend & r_owner;
  assign o_p0_rdata  = o_p0_rvalid ? i_mem_q : '0;
  assign o_p1_rdata  = o_p1_rvalid ? i_mem_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_owner <= 1'b0;
    end else begin
      r_pend  <= w_any & ~w_we;
      r_owner <= w_sel;
      if (w_any) begin
        r_last <= w_sel;
      end
      if (w_keep) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_any && w_lock) begin
        r_state <= w_sel ? StLock1 : StLock0;
        r_cnt   <= CW'(1);
      end else begin
        r_state <= StIdle;
        r_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a reference arbiter and memory image predict each cycle's
// grant and SRAM drive; expected read returns go to a scoreboard drained by a separate monitor.
module tb_dmem_arbiter;

  localparam int AW   = 7;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic          clk;
  logic          rst;
  logic          p0_req, p1_req, p0_we, p1_we, p0_lock, p1_lock;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_cen, mem_wen, mem_oen;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d, mem_q;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_lock(p0_lock), .i_p0_addr(p0_addr),
    .i_p0_wdata(p0_wdata),
    .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_lock(p1_lock), .i_p1_addr(p1_addr),
    .i_p1_wdata(p1_wdata),
    .o_p0_gnt(p0_gnt), .o_p1_gnt(p1_gnt), .o_p0_rvalid(p0_rvalid), .o_p1_rvalid(p1_rvalid),
    .o_p0_rdata(p0_rdata), .o_p1_rdata(p1_rdata),
    .o_mem_cen(mem_cen), .o_mem_wen(mem_wen), .o_mem_oen(mem_oen), .o_mem_a(mem_a),
    .o_mem_d(mem_d), .i_mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model
  logic [DW-1:0] sram [128];
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen) sram[mem_a] <= mem_d;
      else          mem_q <= sram[mem_a];
    end
  end

  typedef struct {int port; logic [DW-1:0] data; int due;} exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference state: what each master is holding, plus the arbitration history.
  logic [DW-1:0] refmem [128];
  bit            req_h [2];
  bit            we_h [2];
  bit            lock_h [2];
  logic [AW-1:0] addr_h [2];
  logic [DW-1:0] wdata_h [2];
  int            m_last, m_burst_port, m_burst_len;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic apply();
    p0_req = req_h[0]; p0_we = we_h[0]; p0_lock = lock_h[0];
    p0_addr = addr_h[0]; p0_wdata = wdata_h[0];
    p1_req = req_h[1]; p1_we = we_h[1]; p1_lock = lock_h[1];
    p1_addr = addr_h[1]; p1_wdata = wdata_h[1];
  endtask

  task automatic model_reset();
    m_last = 1; m_burst_port = -1; m_burst_len = 0;
    for (int p = 0; p < 2; p++) begin
      req_h[p] = 0; we_h[p] = 0; lock_h[p] = 0; addr_h[p] = '0; wdata_h[p] = '0;
    end
  endtask

  // Who should get the SRAM this cycle, by the burst and turn-taking rules.
  function automatic int ref_grant();
    int g = -1;
    if (m_burst_port >= 0 && req_h[m_burst_port] && lock_h[m_burst_port] &&
        m_burst_len < MAXB) begin
      g = m_burst_port;
      m_burst_len++;
    end else begin
      if (req_h[0] && req_h[1]) g = 1 - m_last;
      else if (req_h[0])        g = 0;
      else if (req_h[1])        g = 1;
      if (g >= 0 && lock_h[g]) begin m_burst_port = g; m_burst_len = 1; end
      else                     begin m_burst_port = -1; m_burst_len = 0; end
    end
    if (g >= 0) m_last = g;
    return g;
  endfunction

  task automatic step(input int p_req, input int p_lock);
    int g;
    logic [1:0]  exp_gnt;
    logic [41:0] exp_bus;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      if (!req_h[p] && $urandom_range(0, 99) < p_req) begin
        req_h[p]   = 1;
        we_h[p]    = 1'($urandom_range(0, 1));
        addr_h[p]  = AW'($urandom_range(0, 15));
        wdata_h[p] = $urandom;
      end
      if (p_lock >= 0) lock_h[p] = ($urandom_range(0, 99) < p_lock);
    end
    apply();
    #1;
    g = ref_grant();
    exp_gnt = {g == 1, g == 0};
    if (g < 0) exp_bus = {1'b1, 1'b1, 1'b0, 7'd0, 32'd0};
    else       exp_bus = {1'b0, ~we_h[g], 1'b0, addr_h[g], wdata_h[g]};
    chk("gnt", 64'({p1_gnt, p0_gnt}), 64'(exp_gnt));
    chk("sram_bus", 64'({mem_cen, mem_wen, mem_oen, mem_a, mem_d}), 64'(exp_bus));
    if (g >= 0) begin
      if (we_h[g]) refmem[addr_h[g]] = wdata_h[g];
      else         sb.push_back('{port: g, data: refmem[addr_h[g]], due: cyc + 1});
      req_h[g] = 0;
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    sb.delete();
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      p0_req = 1'b1; p1_req = 1'b1;
      p0_we = 1'($urandom_range(0, 1)); p1_we = 1'($urandom_range(0, 1));
      p0_lock = 1'b1; p1_lock = 1'b0;
      p0_addr = AW'($urandom); p1_addr = AW'($urandom);
      p0_wdata = $urandom; p1_wdata = $urandom;
      #1;
      chk("rst_ctl", 64'({p1_gnt, p0_gnt, p1_rvalid, p0_rvalid, mem_cen, mem_wen, mem_oen}),
          64'(7'b0000110));
      chk("rst_rdata", 64'({p1_rdata, p0_rdata}), 64'd0);
      chk("rst_bus", 64'({mem_a, mem_d}), 64'd0);
      cyc++;
    end
    apply();
    rst = 1'b1;
  endtask

  // Both ports present reads together, as right after reset.
  task automatic tie_reads();
    for (int p = 0; p < 2; p++) begin
      req_h[p] = 1; we_h[p] = 0; lock_h[p] = 0;
      addr_h[p] = AW'(p + 3); wdata_h[p] = $urandom;
    end
  endtask

  // Monitor: every read return is matched against the oldest expected one.
  initial begin
    int got;
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst === 1'b1) begin
        got = p0_rvalid ? 0 : (p1_rvalid ? 1 : -1);
        if (p0_rvalid && p1_rvalid) chk("rvalid_both", 64'(2'b11), 64'(2'b01));
        if (got >= 0) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL rvalid_unexpected cyc=%0d got=port%0d want=none", cyc, got);
          end else begin
            e = sb.pop_front();
            chk("rdata_ret", {got == 1 ? p1_rdata : p0_rdata, 32'(got)},
                {e.data, 32'(e.port)});
          end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
          total++; bad++;
          $display("FAIL rvalid_missing cyc=%0d got=none want=port%0d", cyc, sb[0].port);
          void'(sb.pop_front());
        end
        if (!p0_rvalid) chk("rdata0_idle", 64'(p0_rdata), 64'd0);
        if (!p1_rvalid) chk("rdata1_idle", 64'(p1_rdata), 64'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      sram[i]   = $urandom;
      refmem[i] = sram[i];
    end
    mem_q = '0;
    model_reset();
    apply();
    do_reset(3);

    tie_reads();
    step(0, -1);
    step(0, -1);
    repeat (300) step(60, 30);
    repeat (300) step(95, 90);
    repeat (200) step(30, 50);

    // Reset while a port-0 read is pending: its return must be dropped.
    model_reset();
    req_h[0] = 1; we_h[0] = 0; addr_h[0] = 7'd5;
    step(0, -1);
    @(posedge clk);
    #1;
    do_reset(2);
    tie_reads();
    step(0, -1);
    step(0, -1);
    repeat (200) step(70, 60);

    for (int p = 0; p < 2; p++) req_h[p] = 0;
    repeat (3) step(0, 0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported data SRAM (CEN/WEN/OEN/A/D/Q interface) between the processor's load/store path (port 0) and a second master such as a DMA/loader (port 1). Issues at most one SRAM access per cycle and uses round-robin arbitration with a bounded locked-burst mode. It routes one-cycle-latency read data back to the port that issued the read. Sits between the core/DMA and the data memory macro.

## Interface

- AW, 7, SRAM word-address width
- DW, 32, data width
- MAX_BURST, 4, max consecutive grants to one port under lock (>=1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- p0_req, p1_req  in  1  access request, held until granted
- p0_we, p1_we  in  1  1 = write, 0 = read
- p0_lock, p1_lock  in  1  request exclusive burst
- p0_addr, p1_addr  in  AW  word address
- p0_wdata, p1_wdata  in  DW  write data
- p0_gnt, p1_gnt  out  1  request accepted this cycle (combinational)
- p0_rvalid, p1_rvalid  out  1  read data valid (registered)
- p0_rdata, p1_rdata  out  DW  read data, 0 when rvalid low
- mem_cen  out  1  chip enable, active low
- mem_wen  out  1  0 = write, 1 = read
- mem_oen  out  1  output enable, tied 0
- mem_a  out  AW  SRAM address
- mem_d  out  DW  SRAM write data
- mem_q  in  DW  SRAM read data, valid cycle after read issue

## Operation

- State: FSM {IDLE, LOCK0, LOCK1}, round-robin pointer `last` (last granted port), burst counter `cnt` (width clog2(MAX_BURST+1)), read-return register {pend, owner}.
- IDLE arbitration: only one port requesting -> that port granted. Both requesting -> port != last granted. Update last on every grant.
- Grant in IDLE with granted port's lock=1 -> next state LOCKx, cnt=1. Grant with lock=0 -> stay IDLE.
- LOCKx: if px_req & px_lock & cnt<MAX_BURST -> grant x exclusively, cnt+1. Otherwise the same cycle falls through to IDLE arbitration with last=x (other port wins if requesting). Next state is set by that grant, else IDLE, cnt=0.
- Exhausting MAX_BURST forces a round-robin turn. Port x still requesting with lock is granted again only when the other port is idle, and then starts a new burst with cnt=1.
- Granted port drives SRAM combinationally: mem_cen=0, mem_wen=~we, mem_a=addr, mem_d=wdata. With no grant: mem_cen=1, mem_wen=1, mem_a=0, mem_d=0.
- Granted read -> pend<=1, owner<=port. Next cycle p<owner>_rvalid=1 and p<owner>_rdata=mem_q. Writes produce no rvalid.
- Back-to-back reads, including port changes, are fully pipelined: one rvalid per issued read, in issue order.
- gnt and the SRAM drive are combinational from req/state. Ports must keep req/we/addr/wdata stable until gnt.

## Timing

- Reset (rst low, asynchronous) sets: state IDLE, last=1 (port 0 wins the first tie), cnt=0, pend=0. While rst is low, gnt=0, rvalid=0, rdata=0, mem_cen=1, mem_wen=1, mem_a=0, mem_d=0, mem_oen=0.
- Reset asserted mid-burst or with a read pending: the pending rvalid is dropped and not delivered after release.
- First grant possible in the first cycle with rst high.
- Grant latency 0 cycles when uncontended. A starving port waits at most MAX_BURST cycles.
- Read latency: rvalid exactly 1 cycle after gnt.
- Throughput: 1 access/cycle.
- Lock asserted by the non-granted port is ignored until that port wins.

## Test plan

- Single read: p0 read addr 5 (SRAM[5]=0xDEADBEEF) -> p0_gnt cycle N with mem_cen=0, mem_wen=1, mem_a=5; p0_rvalid=1, p0_rdata=0xDEADBEEF at N+1, low at N+2.
- Tie after reset: both request reads on the first cycle -> p0 granted in cycle 0, p1 in cycle 1. Rvalids at cycles 1 and 2 on the correct ports.
- Round-robin: both hold writes for 6 cycles without lock -> grants alternate 0,1,0,1,0,1. mem_wen=0 and mem_d matches each granted port's wdata.
- Locked burst: p1 lock+req continuously, p0 req from cycle 1, MAX_BURST=4 -> p1 granted at cycles 0-3, p0 at cycle 4, p1 new burst from cycle 5.
- Early unlock: p0 lock drops after 2 grants while p1 is requesting -> p1 granted the next cycle, state IDLE, then LOCK1 if p1_lock=1.
- Reset mid-read: p0 read granted at N, rst low during N+1 before the edge -> p0_rvalid stays 0, all outputs at reset values. After release, p0 wins the first tie.
